// File: rtl/msk_key_loader_pkg.sv
// Shared types and sizing helpers for the masked key loader.
package msk_key_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        KEY,
        WAIT_RND,
        REFRESH,
        DONE
    } state_e;

    function automatic int key_words(input int d, input int nbits,
                                     input int size_feed);
        return (d * nbits) / size_feed;
    endfunction

    function automatic int cnt_width(input int seed_words,
                                     input int key_words_n);
        int m;
        m = (seed_words > key_words_n) ? seed_words : key_words_n;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/msk_key_loader.sv
// Streams PRNG seed then key-share words onto the key holder load bus,
// then issues a single refresh once the refresh PRNG is ready.
module msk_key_loader
    import msk_key_loader_pkg::*;
#(
    parameter int d          = 2,
    parameter int Nbits      = 128,
    parameter int SIZE_FEED  = 32,
    parameter int SEED_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 pre_rst,
    input  logic                 start,
    input  logic [SIZE_FEED-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SIZE_FEED-1:0] data_in,
    output logic                 data_in_valid,
    output logic                 feed_prng_seed,
    output logic                 n_lock_for_seed,
    input  logic                 rnd_ready,
    output logic                 pre_pre_refresh,
    output logic                 busy,
    output logic                 done
);

    localparam int KEY_WORDS = key_words(d, Nbits, SIZE_FEED);
    localparam int CW        = cnt_width(SEED_WORDS, KEY_WORDS);
    localparam logic [CW-1:0] SEED_LAST = CW'(SEED_WORDS - 1);
    localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_WORDS - 1);

    if (((d * Nbits) % SIZE_FEED) != 0) begin : g_bad_feed
        $error("d*Nbits must be a multiple of SIZE_FEED");
    end
    if (SEED_WORDS < 1) begin : g_bad_seed
        $error("SEED_WORDS must be at least 1");
    end

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic          accept;

    assign in_ready        = (state_q == SEED) || (state_q == KEY);
    assign accept          = in_valid && in_ready;
    assign pre_pre_refresh = (state_q == REFRESH);
    assign done            = (state_q == DONE);
    assign busy            = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = SEED;
            SEED:     if (accept && cnt_q == SEED_LAST) state_d = KEY;
            KEY:      if (accept && cnt_q == KEY_LAST) state_d = WAIT_RND;
            WAIT_RND: if (rnd_ready) state_d = REFRESH;
            REFRESH:  state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Seed lock stays closed until the last seed word has left the bus.
    always_ff @(posedge clk) begin
        if (pre_rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            data_in         <= '0;
            data_in_valid   <= 1'b0;
            feed_prng_seed  <= 1'b0;
            n_lock_for_seed <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) begin
                data_in <= in_data;
            end
            data_in_valid   <= accept;
            feed_prng_seed  <= accept && (state_q == SEED);
            n_lock_for_seed <= !((state_q == IDLE && start) ||
                                 (state_q == SEED));
        end
    end

endmodule
